// File: rtl/booth_r8_mul_pipe_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_pkg : shared constants for the radix-8 Booth multiplier        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package booth_pkg;

   typedef logic [4:0] sel_t;

   localparam sel_t SEL_0  = 5'b00001;
   localparam sel_t SEL_1A = 5'b00010;
   localparam sel_t SEL_2A = 5'b00100;
   localparam sel_t SEL_3A = 5'b01000;
   localparam sel_t SEL_4A = 5'b10000;

   localparam int PIPE_LAT = 7;

   function automatic int ndig(input int width);
      return (width + 3) / 3;
   endfunction

endpackage
`default_nettype wire

// File: rtl/booth_r8_mul_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_r8_mul_pipe_if : operand/result stream bundle                  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface booth_r8_mul_pipe_if #(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) ();
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     a;
   logic [WIDTH-1:0]     b;
   logic [1:0]           sm;
   logic [TAG_W-1:0]     tag;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   p;
   logic [TAG_W-1:0]     out_tag;

   modport slave (
      input  in_valid, a, b, sm, tag, out_ready,
      output in_ready, out_valid, p, out_tag
   );

   modport master (
      output in_valid, a, b, sm, tag, out_ready,
      input  in_ready, out_valid, p, out_tag
   );
endinterface
`default_nettype wire

// File: rtl/booth_r8_mul_pipe_ppgen.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_r8_ppgen : one radix-8 digit -> shifted partial product        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module booth_r8_ppgen
   import booth_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int IDX   = 0
) (
   input  logic [3:0]         i_win,
   input  logic [WIDTH+2:0]   i_m1,
   input  logic [WIDTH+2:0]   i_m2,
   input  logic [WIDTH+2:0]   i_m3,
   input  logic [WIDTH+2:0]   i_m4,
   output logic [2*WIDTH-1:0] o_pp,
   output logic               o_neg
);
   localparam int MW = WIDTH + 3;
   localparam int PW = 2 * WIDTH;

   logic [2:0]    w_idx;
   sel_t          w_sel;
   logic [MW-1:0] w_mag;
   logic [PW-1:0] w_ext;

   always_comb begin
      w_sel = SEL_0;
      w_idx = i_win[2:0] ^ {3{i_win[3]}};
      case (w_idx)
         3'b111:         w_sel = SEL_4A;
         3'b110, 3'b101: w_sel = SEL_3A;
         3'b100, 3'b011: w_sel = SEL_2A;
         3'b010, 3'b001: w_sel = SEL_1A;
         default:        w_sel = SEL_0;
      endcase
      w_mag = ({MW{w_sel == SEL_1A}} & i_m1) | ({MW{w_sel == SEL_2A}} & i_m2) |
              ({MW{w_sel == SEL_3A}} & i_m3) | ({MW{w_sel == SEL_4A}} & i_m4);
      w_ext = {{(PW-MW){w_mag[MW-1]}}, w_mag};
   end

   // Ones' complement here; the +1 rides in the correction row.
   assign o_pp  = (w_ext ^ {PW{i_win[3]}}) << (3 * IDX);
   assign o_neg = i_win[3];

endmodule
`default_nettype wire

// File: rtl/booth_r8_mul_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | booth_r8_mul_pipe : stallable radix-8 Booth multiplier with tag      |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module booth_r8_mul_pipe
   import booth_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int TAG_W = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   booth_r8_mul_pipe_if.slave bus
);
   localparam int NDIG = ndig(WIDTH);
   localparam int AW   = WIDTH + 3;
   localparam int BW   = 3 * NDIG + 1;
   localparam int PW   = 2 * WIDTH;
   localparam int NSTG = 8;

   logic                w_en;
   logic [NSTG-1:0]     r_vld;
   logic [TAG_W-1:0]    r_tag [NSTG-1];

   logic [WIDTH-1:0]    r0_a, r0_b;
   logic [1:0]          r0_sm;
   logic [AW-1:0]       r1_a;
   logic [BW-1:0]       r1_b;
   logic [AW-1:0]       r2_m1, r2_m2, r2_m3, r2_m4;
   logic [BW-1:0]       r2_b;
   logic [PW-1:0]       r3_pp [NDIG];
   logic [NDIG-1:0]     r3_neg;
   logic [PW-1:0]       r4_s, r4_c;
   logic [WIDTH-1:0]    r5_lo, r5_shi, r5_chi;
   logic                r5_co;
   logic [PW-1:0]       r6_p;
   logic [PW-1:0]       r_p;
   logic [TAG_W-1:0]    r_out_tag;

   logic [AW-1:0]       w_a_ext;
   logic [BW-1:0]       w_b_ext;
   logic [PW-1:0]       w_pp  [NDIG];
   logic [NDIG-1:0]     w_neg;
   logic [PW-1:0]       w_row [NDIG+1];
   logic [PW-1:0]       w_s   [NDIG-1];
   logic [PW-1:0]       w_c   [NDIG-1];
   logic [WIDTH:0]      w_lo_sum;
   logic [WIDTH-1:0]    w_hi_sum;

   // One global enable: a stalled output freezes every stage.
   assign w_en          = ~(r_vld[NSTG-1] & ~bus.out_ready);
   assign bus.in_ready  = w_en;
   assign bus.out_valid = r_vld[NSTG-1];
   assign bus.p         = r_p;
   assign bus.out_tag   = r_out_tag;

   assign w_a_ext  = {{3{r0_sm[1] & r0_a[WIDTH-1]}}, r0_a};
   assign w_b_ext  = {{(BW-WIDTH-1){r0_sm[0] & r0_b[WIDTH-1]}}, r0_b, 1'b0};
   assign w_lo_sum = {1'b0, r4_s[WIDTH-1:0]} + {1'b0, r4_c[WIDTH-1:0]};
   assign w_hi_sum = r5_shi + r5_chi + {{(WIDTH-1){1'b0}}, r5_co};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld     <= '0;
         r_p       <= '0;
         r_out_tag <= '0;
      end else if (w_en) begin
         r_vld     <= {r_vld[NSTG-2:0], bus.in_valid};
         r_p       <= r6_p;
         r_out_tag <= r_tag[NSTG-2];
      end
   end

   // Raw beat lands in a flop first so extension logic never sees producer timing.
   always_ff @(posedge clk) begin
      if (w_en) begin
         r0_a     <= bus.a;
         r0_b     <= bus.b;
         r0_sm    <= bus.sm;
         r_tag[0] <= bus.tag;
         for (int k = 1; k < NSTG - 1; k++) r_tag[k] <= r_tag[k-1];
         r1_a     <= w_a_ext;
         r1_b     <= w_b_ext;
         r2_m1    <= r1_a;
         r2_m2    <= r1_a << 1;
         r2_m3    <= r1_a + (r1_a << 1);
         r2_m4    <= r1_a << 2;
         r2_b     <= r1_b;
         for (int i = 0; i < NDIG; i++) r3_pp[i] <= w_pp[i];
         r3_neg   <= w_neg;
         r4_s     <= w_s[NDIG-2];
         r4_c     <= w_c[NDIG-2];
         r5_lo    <= w_lo_sum[WIDTH-1:0];
         r5_co    <= w_lo_sum[WIDTH];
         r5_shi   <= r4_s[PW-1:WIDTH];
         r5_chi   <= r4_c[PW-1:WIDTH];
         r6_p     <= {w_hi_sum, r5_lo};
      end
   end

   generate
      for (genvar gi = 0; gi < NDIG; gi++) begin : g_pp
         booth_r8_ppgen #(
            .WIDTH (WIDTH),
            .IDX   (gi)
         ) u_ppgen (
            .i_win (r2_b[3*gi +: 4]),
            .i_m1  (r2_m1),
            .i_m2  (r2_m2),
            .i_m3  (r2_m3),
            .i_m4  (r2_m4),
            .o_pp  (w_pp[gi]),
            .o_neg (w_neg[gi])
         );
      end
   endgenerate

   always_comb begin
      for (int i = 0; i <= NDIG; i++) w_row[i] = '0;
      for (int i = 0; i < NDIG; i++) begin
         w_row[i]          = r3_pp[i];
         w_row[NDIG][3*i]  = r3_neg[i];
      end
   end

   generate
      for (genvar k = 0; k < NDIG - 1; k++) begin : g_csa
         logic [PW-1:0] w_x, w_y, w_z;
         if (k == 0) begin : g_head
            assign w_x = w_row[0];
            assign w_y = w_row[1];
         end else begin : g_tail
            assign w_x = w_s[k-1];
            assign w_y = w_c[k-1];
         end
         assign w_z    = w_row[k+2];
         assign w_s[k] = w_x ^ w_y ^ w_z;
         assign w_c[k] = ((w_x & w_y) | (w_x & w_z) | (w_y & w_z)) << 1;
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/booth_r8_mul_pipe.md
# booth_r8_mul_pipe

Parametrised, stallable radix-8 Booth multiplier for the iCE40 arithmetic library. It is the next generation of the fixed 8-bit radix-8 pipeline, with three changes: operand width is set by a parameter, the pipeline has a valid/ready handshake so it can be back-pressured, and a sideband tag travels with each product. It sits between a stream producer (DSP datapath, filter taps) and a consumer that may stall.

## Interface
Parameters:
- WIDTH, 8: operand width in bits; legal range 4..32.
- TAG_W, 4: width of the sideband tag; legal range 1..16.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand beat present.
- in_ready  out  1  block can accept a beat this cycle.
- a  in  WIDTH  multiplicand.
- b  in  WIDTH  multiplier, which gets Booth-recoded.
- sm  in  2  sm[1] = a is signed, sm[0] = b is signed; sampled per beat.
- tag  in  TAG_W  sideband, returned unchanged with the result.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- p  out  2*WIDTH  product, modulo 2^(2*WIDTH).
- out_tag  out  TAG_W  tag of the result on p.

## Operation
- Derived constant: NDIG = (WIDTH+3)/3, integer division. This is the number of radix-8 digits.
- S1, capture:
  - A is extended to WIDTH+3 bits, sign-extended if sm[1] is set, otherwise zero-extended.
  - B is extended to 3*NDIG+1 bits: one appended LSB of 0, then sign- or zero-extension per sm[0].
- S2, hard multiple and decode:
  - Register A, 2A, 3A and 4A.
  - For each digit i, read bits B[3i+3:3i]. The negate flag is the top bit. The magnitude index is the low 3 bits XORed with the negate flag.
  - Decode the index to a one-hot select: 111 selects 4A; 110 and 101 select 3A; 100 and 011 select 2A; 010 and 001 select 1A; otherwise 0.
- S3, partial product select:
  - PP_i is the selected multiple, sign-extended to 2*WIDTH bits, XORed with the replicated negate flag, then shifted left by 3i.
  - A correction row carries negate flag i at bit 3i.
- S4, reduction: a combinational 3:2 CSA tree reduces the NDIG+1 rows to a sum row and a carry row, which are then registered.
- S5: add the low WIDTH bits of sum and carry; register the result and the carry-out.
- S6: add the high WIDTH bits plus the registered carry.
- S7: output register holding p and out_tag.
- Arithmetic rules: all rows are 2*WIDTH bits wide and every addition discards the carry out of the MSB. The result equals a*b interpreted per sm, truncated to 2*WIDTH bits.
- tag and the valid bit travel alongside the data through every stage.

## Timing
- Latency: a beat accepted at edge N (in_valid and in_ready both high) appears on out_valid and p after edge N+7, provided no stall occurs in between.
- Throughput is one beat per cycle.
- The pipeline stalls globally:
  - Stall condition: stall = out_valid & ~out_ready.
  - in_ready = ~stall. This is a combinational path from out_ready; that path is accepted.
  - While stalled, every stage register, valid bits included, holds its value.
  - Bubbles are not compressed.
- Outputs stay stable while out_valid is high and out_ready is low; this is AXI-style hold.
- in_valid may be high while in_ready is low. That beat is not captured, and the producer must hold it.
- If out_valid and out_ready are both high in the same cycle as an input acceptance, both transfers complete.
- Reset values:
  - All stage valid bits are 0. out_valid = 0, p = 0, out_tag = 0, and therefore in_ready = 1.
  - Internal data registers other than valid bits need no reset.
- Reset asserted mid-operation discards every in-flight beat. The first output after reset release comes from the first beat accepted after release.

## Structure
- Package booth_pkg holds:
  - the function ndig(width);
  - the one-hot select encodings SEL_0, SEL_1A, SEL_2A, SEL_3A, SEL_4A;
  - the constant PIPE_LAT = 7.
- Sub-module booth_r8_ppgen, one instance per digit. It takes the 4-bit digit window and the registered multiples, and produces the S3 partial product and its negate flag. Parameters: WIDTH and the digit index.
- The CSA tree is a generate loop in the top module.

## Test plan
- Unsigned, WIDTH=8: a=255, b=255, sm=00, tag=3 → p=0xFE01 and out_tag=3, with out_valid high exactly 7 cycles after acceptance.
- Signed, WIDTH=8: a=-128 (0x80), b=-128, sm=11 → p=0x4000. Also a=-1 (0xFF) with b unsigned 255, sm=10 → p=0xFF01.
- Back-pressure, WIDTH=8:
  - Stimulus: stream 20 random beats with random sm, holding out_ready low for 5 cycles mid-stream.
  - Required response: in_ready is low for exactly those cycles; no beat is lost or duplicated; results come out in order and match the reference model.
- Reset mid-stream: assert rst_n low with 4 beats in flight → out_valid=0, p=0 and in_ready=1 immediately; after release, no stale results appear.
- WIDTH=16: a=-32768 (sm[1]=1), b=65535 (sm[0]=0) → p=0x80008000. Also an exhaustive random sweep of 10k vectors at WIDTH=5 and WIDTH=13, all sm modes, checked against the behavioural model.
